mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-requester arbiter that shares the single cache-to-memory bus (bus 2) and its MemCTR between two cache instances, e.g. instruction and data caches. It grants whole line transactions round-robin, forwards the owner's command, address and write beats to memory, and routes the memory's response burst back to the owner only. It sits between the cache instances and MemCTR, using the bus-2 command set (NOP=0, RESPONSE=1, READ_LINE=2, WRITE_LINE=3).

## Interface
- ADDR2_BUS_SIZE, 15: line address width.
- DATA2_BUS_SIZE, 16: data beat width.
- CTR2_BUS_SIZE, 2: command/response code width.
- BEATS, 8: data beats per cache line, ≥2.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- C0_CMD / C1_CMD  in  CTR2_BUS_SIZE  requester command.
- C0_ADDR / C1_ADDR  in  ADDR2_BUS_SIZE  requester line address.
- C0_DIN / C1_DIN  in  DATA2_BUS_SIZE  requester write beat.
- C0_GNT / C1_GNT  out  1  requester owns the bus.
- C0_RESP / C1_RESP  out  CTR2_BUS_SIZE  response code routed to the requester.
- C0_DOUT / C1_DOUT  out  DATA2_BUS_SIZE  response beat routed to the requester.
- M_CMD  out  CTR2_BUS_SIZE  command to memory.
- M_ADDR  out  ADDR2_BUS_SIZE  address to memory.
- M_DOUT  out  DATA2_BUS_SIZE  write beat to memory.
- M_RESP  in  CTR2_BUS_SIZE  memory response code.
- M_DIN  in  DATA2_BUS_SIZE  memory response beat.

## Operation
- State registers: state, owner (1 bit), last (1 bit, last granted port), beat counter of width $clog2(BEATS).
- A request is any C*_CMD equal to READ_LINE or WRITE_LINE. NOP and RESPONSE from a requester are not requests.
- IDLE:
  - All outputs are 0.
  - On a rising edge with exactly one request, that port becomes owner.
  - With two requests, the port ≠ last becomes owner.
  - The arbiter records the command type, clears the beat counter and moves to FWD.
- FWD:
  - M_CMD, M_ADDR and M_DOUT combinationally follow the owner's C*_CMD, C*_ADDR and C*_DIN.
  - The owner's GNT is 1.
  - READ_LINE: one cycle, then WAIT.
  - WRITE_LINE: BEATS cycles with the counter incrementing each cycle, then WAIT. The counter advances even if the owner changes its inputs.
- WAIT:
  - M_CMD, M_ADDR and M_DOUT are 0. GNT stays 1.
  - Each cycle with M_RESP == RESPONSE counts one beat. Cycles with M_RESP == NOP do not count.
- RET (WAIT and RET are one counting phase):
  - The owner's C*_RESP and C*_DOUT equal M_RESP and M_DIN in every WAIT cycle.
  - After the BEATS-th RESPONSE beat is sampled: last ← owner, go to IDLE, GNT drops.
- The non-owner's RESP and DOUT are always 0, and its GNT is 0.
- M_RESP in IDLE or FWD is ignored and is not forwarded.
- Requester obligations:
  - Hold CMD, ADDR and beat 0 stable until GNT is seen.
  - A write presents beat k in the k-th GNT cycle of FWD.
  - Release CMD to NOP when FWD ends. A request still held after RET is treated as a new transaction.

## Timing
- Reset (RESET=0, asynchronous): state=IDLE, last=1 (port 0 wins the first tie), counter=0, all outputs 0. This applies immediately, including mid-transaction. The aborted owner's GNT drops in the same cycle.
- A request sampled at edge N gives GNT=1 and beat 0 on M_* during cycle N→N+1.
- The first response beat seen at edge M is forwarded combinationally in the same cycle.
- The last response beat at edge M gives IDLE after M. The earliest next grant is at edge M+1, so there is one dead cycle between transactions.
- Grant latency for a waiting requester equals the remaining owner transaction plus one cycle.

## Test plan
- Read, single port: C0 READ_LINE addr 0x012A at edge 0.
  - Cycle 0–1: C0_GNT=1, M_CMD=2, M_ADDR=0x012A.
  - Memory then returns 8 RESPONSE beats 0x1111…0x8888. C0_DOUT shows the same beats. C1 sees 0. GNT drops after the 8th beat.
- Write, port 1: C1 WRITE_LINE addr 0x7FFF, beats 0xA000–0xA007.
  - M_DOUT shows the 8 beats on 8 consecutive GNT cycles, then M_CMD=0.
  - The 8-beat response goes to C1 only.
- Simultaneous requests after reset: port 0 is served first, then port 1 after one idle cycle. A second tie after that is granted to port 0 again (alternation).
- Request during a busy transaction: C1 requests during the C0 WAIT phase. C1_GNT stays 0 and rises exactly one cycle after C0's last response beat.
- Reset mid-WAIT (beat 3 of 8): all outputs are 0 immediately. A new C1 read after reset is granted normally and memory beats are counted from 0.
- Spurious traffic:
  - M_RESP=RESPONSE in IDLE: no forwarding, state stays IDLE.
  - NOP gaps inside a response burst: not counted, GNT is held until 8 RESPONSE beats have arrived.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one cache-to-memory bus between two cache ports.
// Grants whole line transactions, forwards the owner's traffic and routes the response burst back.
module mem_bus_arbiter #(
  parameter int unsigned ADDR2_BUS_SIZE = 15,
  parameter int unsigned DATA2_BUS_SIZE = 16,
  parameter int unsigned CTR2_BUS_SIZE  = 2,
  parameter int unsigned BEATS          = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [CTR2_BUS_SIZE-1:0]  C0_CMD,
  input  logic [ADDR2_BUS_SIZE-1:0] C0_ADDR,
  input  logic [DATA2_BUS_SIZE-1:0] C0_DIN,
  input  logic [CTR2_BUS_SIZE-1:0]  C1_CMD,
  input  logic [ADDR2_BUS_SIZE-1:0] C1_ADDR,
  input  logic [DATA2_BUS_SIZE-1:0] C1_DIN,
  output logic                      C0_GNT,
  output logic                      C1_GNT,
  output logic [CTR2_BUS_SIZE-1:0]  C0_RESP,
  output logic [CTR2_BUS_SIZE-1:0]  C1_RESP,
  output logic [DATA2_BUS_SIZE-1:0] C0_DOUT,
  output logic [DATA2_BUS_SIZE-1:0] C1_DOUT,
  output logic [CTR2_BUS_SIZE-1:0]  M_CMD,
  output logic [ADDR2_BUS_SIZE-1:0] M_ADDR,
  output logic [DATA2_BUS_SIZE-1:0] M_DOUT,
  input  logic [CTR2_BUS_SIZE-1:0]  M_RESP,
  input  logic [DATA2_BUS_SIZE-1:0] M_DIN
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CTR2_BUS_SIZE-1:0] CMD_NOP   = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] CMD_RESP  = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] CMD_READ  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] CMD_WRITE = CTR2_BUS_SIZE'(3);
  localparam logic [CNT_W-1:0]         LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_WAIT
  } state_t;

  state_t             state;
  logic               owner;
  logic               last;
  logic               is_write;
  logic [CNT_W-1:0]   cnt;

  logic                     req0;
  logic                     req1;
  logic                     pick;
  logic [CTR2_BUS_SIZE-1:0] pick_cmd;

  assign req0 = (C0_CMD == CMD_READ) || (C0_CMD == CMD_WRITE);
  assign req1 = (C1_CMD == CMD_READ) || (C1_CMD == CMD_WRITE);

  // On a tie the port that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last;
    end else if (req1) begin
      pick = 1'b1;
    end
    pick_cmd = pick ? C1_CMD : C0_CMD;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      is_write <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            owner    <= pick;
            is_write <= (pick_cmd == CMD_WRITE);
            cnt      <= '0;
            state    <= S_FWD;
          end
        end
        S_FWD: begin
          // Write beats advance on time regardless of what the owner drives.
          if (!is_write || (cnt == LAST_BEAT)) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (M_RESP == CMD_RESP) begin
            if (cnt == LAST_BEAT) begin
              cnt   <= '0;
              last  <= owner;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Bus steering decoded from the registered state; data paths are pass-through.
  always_comb begin
    C0_GNT  = 1'b0;
    C1_GNT  = 1'b0;
    C0_RESP = CMD_NOP;
    C1_RESP = CMD_NOP;
    C0_DOUT = '0;
    C1_DOUT = '0;
    M_CMD   = CMD_NOP;
    M_ADDR  = '0;
    M_DOUT  = '0;
    if (state != S_IDLE) begin
      C0_GNT = ~owner;
      C1_GNT = owner;
    end
    if (state == S_FWD) begin
      M_CMD  = owner ? C1_CMD  : C0_CMD;
      M_ADDR = owner ? C1_ADDR : C0_ADDR;
      M_DOUT = owner ? C1_DIN  : C0_DIN;
    end
    if (state == S_WAIT) begin
      if (owner) begin
        C1_RESP = M_RESP;
        C1_DOUT = M_DIN;
      end else begin
        C0_RESP = M_RESP;
        C0_DOUT = M_DIN;
      end
    end
  end

endmodule
